// File: rtl/lcd_pkg.sv
// Shared HD44780 bus definitions: sequencer state encoding, command codes and default timing.
package lcd_pkg;

    localparam int SETUP_CYC_DEF     = 2;
    localparam int E_HIGH_CYC_DEF    = 4;
    localparam int HOLD_CYC_DEF      = 2;
    localparam int EXEC_CYC_DEF      = 40;
    localparam int LONG_EXEC_CYC_DEF = 1640;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_EXEC_WAIT,
        ST_POLL_SETUP,
        ST_POLL_E,
        ST_POLL_CHECK
    } state_e;

    // Clear and both home encodings (0x02/0x03, bit 0 is don't-care) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && ((d == CMD_CLEAR) || ((d & 8'hFE) == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter with zero flag; a load wins over counting, and the count parks at zero.
module lcd_cycle_timer #(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_n_i) begin
        if (reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 bus owner: fixed-priority arbitration (init over writer) and setup/E/hold/exec-wait sequencing.
// Optional feature macro LCD_BUSY_POLL_EN replaces the fixed exec wait with busy-flag polling.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = SETUP_CYC_DEF,
    parameter int E_HIGH_CYC    = E_HIGH_CYC_DEF,
    parameter int HOLD_CYC      = HOLD_CYC_DEF,
    parameter int EXEC_CYC      = EXEC_CYC_DEF,
    parameter int LONG_EXEC_CYC = LONG_EXEC_CYC_DEF
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       init_req_i,
    input  logic       init_rs_i,
    input  logic [7:0] init_data_i,
    output logic       init_ack_o,
    input  logic       init_done_i,
    input  logic       wr_req_i,
    input  logic       wr_rs_i,
    input  logic [7:0] wr_data_i,
    output logic       wr_ack_o,
    output logic       lcd_busy_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic       e_o,
    output logic [7:0] data_o,
    output logic       data_oe_o,
    input  logic [7:0] data_in_i
);

    localparam int CW = $clog2(LONG_EXEC_CYC + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_E     = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(LONG_EXEC_CYC - 1);

    state_e        state_q, state_d;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          init_ack_q, wr_ack_q;
    logic          e_q, e_d;
    logic          grant_init, grant_wr;
    logic          tmr_load, tmr_zero;
    logic [CW-1:0] tmr_val;
    logic          unused_data_in;

`ifdef LCD_BUSY_POLL_EN
    logic          busy_flag_q;
    logic [CW-1:0] poll_tmo_q;
    logic          rw_q;
    logic          in_poll;

    assign in_poll = (state_q == ST_POLL_SETUP) || (state_q == ST_POLL_E) ||
                     (state_q == ST_POLL_CHECK);
`endif

    lcd_cycle_timer #(.W(CW)) u_timer (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        grant_init = 1'b0;
        grant_wr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_req_i) begin
                    grant_init = 1'b1;
                end else if (wr_req_i && init_done_i) begin
                    grant_wr = 1'b1;
                end
                if (grant_init || grant_wr) begin
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_E_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_E;
                end
            end
            ST_E_HIGH: begin
                if (tmr_zero) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
`ifdef LCD_BUSY_POLL_EN
                    state_d  = ST_POLL_SETUP;
                    tmr_val  = LD_SETUP;
`else
                    state_d  = ST_EXEC_WAIT;
                    tmr_val  = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
`endif
                end
            end
            ST_EXEC_WAIT: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef LCD_BUSY_POLL_EN
            ST_POLL_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_POLL_E;
                    tmr_load = 1'b1;
                    tmr_val  = LD_E;
                end
            end
            ST_POLL_E: begin
                if (tmr_zero) begin
                    state_d = ST_POLL_CHECK;
                end
            end
            ST_POLL_CHECK: begin
                if (busy_flag_q) begin
                    state_d  = ST_POLL_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef LCD_BUSY_POLL_EN
        // A stuck busy flag must not hang the bus; the phase timer is cleared on forced exit.
        if (in_poll && (poll_tmo_q == '0)) begin
            state_d  = ST_IDLE;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end
        e_d = (state_d == ST_E_HIGH) || (state_d == ST_POLL_E);
`else
        e_d = (state_d == ST_E_HIGH);
`endif
    end

    always_ff @(posedge clk_i or posedge reset_n_i) begin
        if (reset_n_i) begin
            state_q    <= ST_IDLE;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            init_ack_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            e_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ack_q <= grant_init;
            wr_ack_q   <= grant_wr;
            e_q        <= e_d;
            if (grant_init) begin
                rs_q   <= init_rs_i;
                data_q <= init_data_i;
            end else if (grant_wr) begin
                rs_q   <= wr_rs_i;
                data_q <= wr_data_i;
            end
        end
    end

`ifdef LCD_BUSY_POLL_EN
    always_ff @(posedge clk_i or posedge reset_n_i) begin
        if (reset_n_i) begin
            busy_flag_q <= 1'b0;
            poll_tmo_q  <= '0;
            rw_q        <= 1'b0;
        end else begin
            rw_q <= (state_d == ST_POLL_SETUP) || (state_d == ST_POLL_E) ||
                    (state_d == ST_POLL_CHECK);
            if ((state_q == ST_POLL_E) && tmr_zero) begin
                busy_flag_q <= data_in_i[7];
            end
            if ((state_q == ST_HOLD) && (state_d == ST_POLL_SETUP)) begin
                poll_tmo_q <= LD_LONG;
            end else if (in_poll && (poll_tmo_q != '0)) begin
                poll_tmo_q <= poll_tmo_q - CW'(1);
            end
        end
    end

    assign rw_o      = rw_q;
    assign data_oe_o = !rw_q;
    assign rs_o      = rw_q ? 1'b0 : rs_q;
`else
    assign rw_o      = 1'b0;
    assign data_oe_o = 1'b1;
    assign rs_o      = rs_q;
`endif

    assign unused_data_in = ^data_in_i;
    assign init_ack_o     = init_ack_q;
    assign wr_ack_o       = wr_ack_q;
    assign e_o            = e_q;
    assign data_o         = data_q;
    assign lcd_busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Scoreboard bench for lcd_bus_sequencer (default build, fixed exec delays).
module tb_lcd_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_req = 1'b0, init_rs = 1'b0, init_done = 1'b0;
    logic [7:0] init_data = 8'h00;
    logic       wr_req = 1'b0, wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       init_ack_o, wr_ack_o, lcd_busy_o, rs_o, rw_o, e_o, data_oe_o;
    logic [7:0] data_o;

    typedef struct {
        bit         port;
        bit         rs;
        logic [7:0] data;
        int         dur;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_active = 1'b0;

    always #5 clk = ~clk;

    lcd_bus_sequencer dut (
        .clk_i       (clk),
        .reset_n_i   (rst),
        .init_req_i  (init_req),
        .init_rs_i   (init_rs),
        .init_data_i (init_data),
        .init_ack_o  (init_ack_o),
        .init_done_i (init_done),
        .wr_req_i    (wr_req),
        .wr_rs_i     (wr_rs),
        .wr_data_i   (wr_data),
        .wr_ack_o    (wr_ack_o),
        .lcd_busy_o  (lcd_busy_o),
        .rs_o        (rs_o),
        .rw_o        (rw_o),
        .e_o         (e_o),
        .data_o      (data_o),
        .data_oe_o   (data_oe_o),
        .data_in_i   (data_in)
    );

    // Reference timing: setup 2 + E 4 + hold 2, then 1640 for clear/home (RS=0, 0x01..0x03) or 40.
    function automatic int model_dur(input bit rs, input logic [7:0] d);
        bit long_cmd;
        long_cmd = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
        return 2 + 4 + 2 + (long_cmd ? 1640 : 40);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push(input bit port, input bit rs, input logic [7:0] d, input bit b2b);
        exp_t e;
        e.port = port;
        e.rs   = rs;
        e.data = d;
        e.dur  = model_dur(rs, d);
        e.b2b  = b2b;
        exp_q.push_back(e);
    endtask

    task automatic issue(input bit port, input bit rs, input logic [7:0] d, input bit b2b);
        push(port, rs, d, b2b);
        if (!port) begin
            init_rs = rs; init_data = d; init_req = 1'b1;
        end else begin
            wr_rs = rs; wr_data = d; wr_req = 1'b1;
        end
    endtask

    task automatic wait_req_low();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if (!init_req && !wr_req) return;
        end
        timeout("req_ack_wait");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && !mon_active && !lcd_busy_o && !init_req && !wr_req) return;
        end
        timeout("idle_wait");
    endtask

    task automatic wait_e_high();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (e_o) return;
        end
        timeout("e_high_wait");
    endtask

    // Requester side: drop req and scramble the inputs as soon as the ack is seen.
    initial begin : responder
        forever begin
            @(negedge clk);
            if (init_ack_o) begin
                init_req  = 1'b0;
                init_rs   = 1'($urandom);
                init_data = 8'($urandom);
            end
            if (wr_ack_o) begin
                wr_req  = 1'b0;
                wr_rs   = 1'($urandom);
                wr_data = 8'($urandom);
            end
        end
    end

    initial begin : monitor
        int   cyc, ack_cyc, last_ack, last_dur, rise, ehigh;
        bit   bus_ok, side_ok;
        exp_t cur;
        cyc = 0; ack_cyc = 0; last_ack = 0; last_dur = 0; rise = -1; ehigh = 0;
        bus_ok = 1'b1; side_ok = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mon_active = 1'b0;
            end else if (init_ack_o || wr_ack_o) begin
                chk("dual_ack", int'(init_ack_o & wr_ack_o), 0);
                chk("ack_while_busy", int'(mon_active), 0);
                chk("busy_at_ack", int'(lcd_busy_o), 1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: init_ack=%0d wr_ack=%0d with no request pending",
                             init_ack_o, wr_ack_o);
                    mon_active = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    chk("ack_port", int'(wr_ack_o), int'(cur.port));
                    if (cur.b2b) chk("next_grant_gap", cyc - last_ack, last_dur + 1);
                    last_ack = cyc;
                    last_dur = cur.dur;
                    ack_cyc  = cyc;
                    rise = -1; ehigh = 0; bus_ok = 1'b1; side_ok = 1'b1;
                    if (rs_o !== cur.rs || data_o !== cur.data) bus_ok = 1'b0;
                    mon_active = 1'b1;
                end
            end else if (mon_active) begin
                if (rs_o !== cur.rs || data_o !== cur.data) bus_ok = 1'b0;
                if (rw_o !== 1'b0 || data_oe_o !== 1'b1) side_ok = 1'b0;
                if (e_o) begin
                    if (rise < 0) rise = cyc - ack_cyc;
                    ehigh++;
                end
                if (!lcd_busy_o) begin
                    chk("e_rise_after_ack", rise, 2);
                    chk("e_high_width", ehigh, 4);
                    chk("bus_rs_data", int'(bus_ok), 1);
                    chk("rw_oe_write", int'(side_ok), 1);
                    chk("busy_length", cyc - ack_cyc, cur.dur);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int ack_cnt;
        logic [7:0] bnd_d [7];
        bit         bnd_rs[7];
        bnd_d = '{8'h38, 8'h01, 8'h00, 8'h03, 8'h01, 8'h04, 8'h02};
        bnd_rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_e", int'(e_o), 0);
        chk("rst_rw", int'(rw_o), 0);
        chk("rst_rs", int'(rs_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_data_oe", int'(data_oe_o), 1);
        chk("rst_init_ack", int'(init_ack_o), 0);
        chk("rst_wr_ack", int'(wr_ack_o), 0);
        chk("rst_busy", int'(lcd_busy_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed init writes incl. clear/home and their neighbours.
        for (int k = 0; k < 7; k++) begin
            wait_idle();
            @(posedge clk); #2;
            issue(1'b0, bnd_rs[k], bnd_d[k], 1'b0);
            wait_req_low();
        end

        // Back-to-back init requests with the second raised during the first cycle.
        wait_idle();
        @(posedge clk); #2;
        issue(1'b0, 1'b0, 8'h0C, 1'b0);
        wait_req_low();
        @(posedge clk); #2;
        issue(1'b0, 1'b0, 8'h06, 1'b1);
        wait_req_low();

        // init_done dropping mid-cycle lets the current writer cycle complete.
        wait_idle();
        init_done = 1'b1;
        @(posedge clk); #2;
        issue(1'b1, 1'b1, 8'h41, 1'b0);
        wait_e_high();
        init_done = 1'b0;

        // Writer held off while init_done=0, then granted in the next IDLE.
        wait_idle();
        @(posedge clk); #2;
        issue(1'b1, 1'b1, 8'h5A, 1'b0);
        ack_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (wr_ack_o || init_ack_o) ack_cnt++;
        end
        chk("wr_blocked_no_ack", ack_cnt, 0);
        chk("wr_blocked_pending", int'(wr_req), 1);
        @(posedge clk); #2;
        init_done = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("wr_ack_after_done", int'(wr_ack_o), 1);

        // Simultaneous requests: init first, writer right after.
        wait_idle();
        @(posedge clk); #2;
        push(1'b0, 1'b0, 8'h80, 1'b0);
        push(1'b1, 1'b1, 8'h48, 1'b1);
        init_rs = 1'b0; init_data = 8'h80;
        wr_rs = 1'b1; wr_data = 8'h48;
        init_req = 1'b1; wr_req = 1'b1;
        wait_req_low();

        // Randomized traffic.
        wait_idle();
        for (int k = 0; k < 24; k++) begin
            bit         port, rs, b2b;
            logic [7:0] d;
            port = 1'($urandom_range(0, 1));
            rs   = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            b2b  = (k > 0) && ($urandom_range(0, 1) == 1);
            if (!b2b) begin
                wait_idle();
                repeat ($urandom_range(0, 5)) @(posedge clk);
            end
            @(posedge clk); #2;
            issue(port, rs, d, b2b);
            wait_req_low();
        end

        // Reset during E high: E drops at once and the lost transfer is not acked again.
        wait_idle();
        @(posedge clk); #2;
        issue(1'b0, 1'b0, 8'h28, 1'b0);
        wait_e_high();
        rst = 1'b1;
        #1;
        chk("rst_mid_e", int'(e_o), 0);
        chk("rst_mid_busy", int'(lcd_busy_o), 0);
        chk("rst_mid_data", int'(data_o), 0);
        chk("rst_mid_rs", int'(rs_o), 0);
        chk("rst_mid_acks", int'(init_ack_o | wr_ack_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (wr_ack_o || init_ack_o) ack_cnt++;
        end
        chk("no_ack_after_reset", ack_cnt, 0);

        wait_idle();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
